// File: rtl/pll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_cfg_pkg
// Description : Shared definitions for the video PLL dynamic controller:
//               controller state encoding, divider field width, power-up
//               divider/duty defaults and the zero-field clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_cfg_pkg;

  localparam int RATIO_W = 10;

  // Power-up operating point: 50 MHz reference / 2 * 25 gives a 625 MHz VCO.
  // Output dividers {out2, out1, out0} = {26, 5, 25}. out0 is in the LSBs.
  localparam logic [RATIO_W-1:0]   VID_RATIOI = 10'd2;
  localparam logic [RATIO_W-1:0]   VID_RATIOF = 10'd25;
  localparam logic [3*RATIO_W-1:0] VID_RATIO  = {10'd26, 10'd5, 10'd25};
  localparam logic [3*RATIO_W-1:0] VID_DUTY   = {10'd26, 10'd5, 10'd25};

  typedef enum logic [2:0] {
    ST_RST_HOLD   = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE_CHK = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } pll_state_t;

  // The PLL treats a zero divider as illegal, so a zero field becomes 1.
  function automatic logic [RATIO_W-1:0] clamp_ratio(input logic [RATIO_W-1:0] v);
    return (v == '0) ? RATIO_W'(1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_sync.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_sync
// Description : Multi-flop synchroniser bringing the asynchronous PLL LOCK
//               flag into the controller clock domain.
// Ports       : clk      - destination clock
//               rst      - asynchronous active-high reset (clears the chain)
//               async_in - asynchronous input
//               sync_out - synchronised output, DEPTH cycles of latency
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sync #(
  parameter int DEPTH = 2   // must be 2 or more
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], async_in};
    end
  end

  assign sync_out = stages[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/pll_dyn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_dyn_ctrl
// Description : Run-time reconfiguration and lock supervision for the video
//               PLL. Sequences PLL reset around divider changes, qualifies
//               lock, gates output clocks until lock is stable, retries on
//               lock timeout and flags failure when retries run out.
// Ports       : clkin1        - free-running reference, sole clock
//               pll_rst       - asynchronous active-high reset
//               cfg_valid/cfg_ready - new-configuration handshake
//               cfg_ratioi/cfg_ratiof/cfg_ratio/cfg_duty - requested ratios
//               pll_lock      - raw asynchronous PLL LOCK
//               dyn_idiv/dyn_fdiv/dyn_odiv/dyn_duty - to PLL dynamic ports
//               pll_core_rst  - to PLL RST
//               clk_en        - per-output clock enables (CLKOUTn_SYN)
//               locked        - qualified lock
//               busy          - sequencing in progress (not RUN / FAIL)
//               err           - sticky retry-exhausted flag
//               retry_cnt     - failed attempts in the current sequence
// Revision    : 1.0 - initial release
// ============================================================================
module pll_dyn_ctrl #(
  parameter int                              NUM_OUT          = 3,
  // Must match pll_cfg_pkg::RATIO_W; the clamp helper is sized by it.
  parameter int                              RATIO_W          = pll_cfg_pkg::RATIO_W,
  parameter logic [RATIO_W-1:0]              DEF_RATIOI       = pll_cfg_pkg::VID_RATIOI,
  parameter logic [RATIO_W-1:0]              DEF_RATIOF       = pll_cfg_pkg::VID_RATIOF,
  parameter logic [NUM_OUT*RATIO_W-1:0]      DEF_RATIO        = pll_cfg_pkg::VID_RATIO,
  parameter logic [NUM_OUT*RATIO_W-1:0]      DEF_DUTY         = pll_cfg_pkg::VID_DUTY,
  parameter int                              RST_HOLD_CYC     = 16,
  parameter int                              LOCK_STABLE_CYC  = 1024,  // 2 or more
  parameter int                              LOCK_TIMEOUT_CYC = 65536,
  parameter int                              MAX_RETRY        = 3
) (
  input  logic                               clkin1,
  input  logic                               pll_rst,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [RATIO_W-1:0]                 cfg_ratioi,
  input  logic [RATIO_W-1:0]                 cfg_ratiof,
  input  logic [NUM_OUT*RATIO_W-1:0]         cfg_ratio,
  input  logic [NUM_OUT*RATIO_W-1:0]         cfg_duty,
  input  logic                               pll_lock,
  output logic [RATIO_W-1:0]                 dyn_idiv,
  output logic [RATIO_W-1:0]                 dyn_fdiv,
  output logic [NUM_OUT*RATIO_W-1:0]         dyn_odiv,
  output logic [NUM_OUT*RATIO_W-1:0]         dyn_duty,
  output logic                               pll_core_rst,
  output logic [NUM_OUT-1:0]                 clk_en,
  output logic                               locked,
  output logic                               busy,
  output logic                               err,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

  import pll_cfg_pkg::*;

  // One down-counter is shared by the three timed states.
  localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  // The WAIT_LOCK cycle that first sees lock_s high is the first stable
  // cycle, so STABLE_CHK itself only has to cover LOCK_STABLE_CYC-1 cycles.
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(LOCK_STABLE_CYC - 2);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

  pll_state_t               state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [RETRY_W-1:0]       retry_nxt;
  logic                     err_nxt;
  logic                     lock_s;
  logic                     accept;

  logic [RATIO_W-1:0]         shadow_idiv, shadow_fdiv;
  logic [NUM_OUT*RATIO_W-1:0] shadow_odiv, shadow_duty;
  logic [NUM_OUT*RATIO_W-1:0] cfg_ratio_c, cfg_duty_c;

  pll_lock_sync #(
    .DEPTH    (2)
  ) u_lock_sync (
    .clk      (clkin1),
    .rst      (pll_rst),
    .async_in (pll_lock),
    .sync_out (lock_s)
  );

  // cfg_ready is only high in RUN and FAIL, so accept implies one of them.
  assign accept = cfg_valid && cfg_ready;

  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_clamp
      assign cfg_ratio_c[i*RATIO_W +: RATIO_W] = clamp_ratio(cfg_ratio[i*RATIO_W +: RATIO_W]);
      assign cfg_duty_c[i*RATIO_W +: RATIO_W]  = clamp_ratio(cfg_duty[i*RATIO_W +: RATIO_W]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    err_nxt   = err;

    unique case (state)
      ST_RST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = TMO_LOAD;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_STABLE_CHK;
          cnt_nxt   = STB_LOAD;
        end else if (cnt == '0) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          if (retry_cnt == RETRY_LAST) begin
            state_nxt = ST_FAIL;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_RST_HOLD;
            cnt_nxt   = HOLD_LOAD;
          end
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end

      ST_STABLE_CHK: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = TMO_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_RUN;
          retry_nxt = '0;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
        end
      end

      ST_RUN: begin
        retry_nxt = '0;
        if (!lock_s) begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end

      ST_FAIL: begin
        // Parked with the PLL in reset until a new configuration arrives.
      end

      default: begin
        state_nxt = ST_RST_HOLD;
        cnt_nxt   = HOLD_LOAD;
      end
    endcase

    // A configuration accept overrides a simultaneous lock loss in RUN.
    if (accept) begin
      state_nxt = ST_RST_HOLD;
      cnt_nxt   = HOLD_LOAD;
      retry_nxt = '0;
      err_nxt   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, counter and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      state     <= ST_RST_HOLD;
      cnt       <= HOLD_LOAD;
      retry_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      err       <= err_nxt;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state transition while still coming straight from flops.
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      pll_core_rst <= 1'b1;
      clk_en       <= '0;
      locked       <= 1'b0;
      busy         <= 1'b1;
      cfg_ready    <= 1'b0;
    end else begin
      pll_core_rst <= (state_nxt == ST_RST_HOLD) || (state_nxt == ST_FAIL);
      clk_en       <= {NUM_OUT{state_nxt == ST_RUN}};
      locked       <= (state_nxt == ST_RUN);
      busy         <= !((state_nxt == ST_RUN) || (state_nxt == ST_FAIL));
      cfg_ready    <= (state_nxt == ST_RUN) || (state_nxt == ST_FAIL);
    end
  end

  // --------------------------------------------------------------------------
  // Shadow and dynamic ratio registers. The shadow only changes on accept
  // (never inside RST_HOLD), so copying it throughout RST_HOLD has the same
  // effect as a first-cycle load and keeps dyn_* moving only under PLL reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clkin1 or posedge pll_rst) begin
    if (pll_rst) begin
      shadow_idiv <= DEF_RATIOI;
      shadow_fdiv <= DEF_RATIOF;
      shadow_odiv <= DEF_RATIO;
      shadow_duty <= DEF_DUTY;
      dyn_idiv    <= DEF_RATIOI;
      dyn_fdiv    <= DEF_RATIOF;
      dyn_odiv    <= DEF_RATIO;
      dyn_duty    <= DEF_DUTY;
    end else begin
      if (accept) begin
        shadow_idiv <= clamp_ratio(cfg_ratioi);
        shadow_fdiv <= clamp_ratio(cfg_ratiof);
        shadow_odiv <= cfg_ratio_c;
        shadow_duty <= cfg_duty_c;
      end
      if (state == ST_RST_HOLD) begin
        dyn_idiv <= shadow_idiv;
        dyn_fdiv <= shadow_fdiv;
        dyn_odiv <= shadow_odiv;
        dyn_duty <= shadow_duty;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pll_dyn_ctrl.md
# pll_dyn_ctrl

Run-time reconfiguration and lock-supervision controller for the GTP_PLL_E1 video PLL. It generalises the fixed-ratio HDMI PLL wrapper to `NUM_OUT` outputs with dynamic input, feedback, output and duty ratios. It sequences PLL reset around every divider change, qualifies lock, gates downstream clocks until lock is stable, and retries or flags failure. It sits between the video-mode register block and the PLL primitive's dynamic ports (`RATIOI`/`RATIOF`/`RATIOn`/`DUTYn`/`RST`/`CLKOUTn_SYN`).

## Interface
Parameters:
- `NUM_OUT`, 3: number of PLL outputs controlled (1–5).
- `RATIO_W`, 10: divider/duty field width.
- `DEF_RATIOI`, 2: input divider at reset.
- `DEF_RATIOF`, 25: feedback divider at reset.
- `DEF_RATIO`, {26,5,25}: packed `NUM_OUT*RATIO_W` output dividers at reset; out0 in the LSBs.
- `DEF_DUTY`, {26,5,25}: packed duty values at reset.
- `RST_HOLD_CYC`, 16: cycles `pll_core_rst` is held per attempt.
- `LOCK_STABLE_CYC`, 1024: consecutive synchronised-high lock cycles required.
- `LOCK_TIMEOUT_CYC`, 65536: wait-for-lock limit per attempt.
- `MAX_RETRY`, 3: failed attempts before FAIL.

Ports:
- `clkin1` in 1: free-running 50 MHz reference; sole clock of this block.
- `pll_rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1 / `cfg_ready` out 1: new-configuration handshake.
- `cfg_ratioi`, `cfg_ratiof` in `RATIO_W`: requested input and feedback dividers.
- `cfg_ratio`, `cfg_duty` in `NUM_OUT*RATIO_W`: requested output dividers and duties.
- `pll_lock` in 1: raw PLL `LOCK`, asynchronous.
- `dyn_idiv`, `dyn_fdiv` out `RATIO_W`: to PLL `RATIOI` and `RATIOF`.
- `dyn_odiv`, `dyn_duty` out `NUM_OUT*RATIO_W`: to PLL `RATIOn` and `DUTYn`.
- `pll_core_rst` out 1: to PLL `RST`.
- `clk_en` out `NUM_OUT`: to `CLKOUTn_SYN`.
- `locked` out 1: qualified lock.
- `busy` out 1: high in every state except RUN and FAIL.
- `err` out 1: sticky, set when retries are exhausted.
- `retry_cnt` out `$clog2(MAX_RETRY+1)`: failed attempts in the current sequence.

## Operation
- Reset values:
  - State RST_HOLD; `pll_core_rst`=1; `clk_en`=0; `locked`=0; `busy`=1; `err`=0; `cfg_ready`=0; `retry_cnt`=0.
  - `dyn_*` = `DEF_*`; shadow registers = `DEF_*`.
- `pll_lock` passes through a 2-flop synchroniser to give `lock_s`. Only `lock_s` is used internally.
- One shared down-counter serves all three timed states. Its width is `$clog2` of the largest of `RST_HOLD_CYC`, `LOCK_STABLE_CYC` and `LOCK_TIMEOUT_CYC`, plus 1.
- States and transitions:
  - **RST_HOLD**: `pll_core_rst`=1. On the first cycle, the shadow registers are copied to `dyn_*`. After `RST_HOLD_CYC` cycles, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_core_rst`=0.
    - `lock_s`=1 → STABLE_CHK.
    - `LOCK_TIMEOUT_CYC` elapses → `retry_cnt`++.
    - If `retry_cnt` now equals `MAX_RETRY` → FAIL; otherwise → RST_HOLD.
  - **STABLE_CHK**: counts consecutive cycles of `lock_s`=1.
    - `lock_s`=0 → WAIT_LOCK, with the timeout restarted.
    - Count reaches `LOCK_STABLE_CYC` → RUN.
  - **RUN**: `locked`=1; `clk_en`=all ones; `cfg_ready`=1; `retry_cnt` cleared.
    - `lock_s`=0 → RST_HOLD, with `locked` and `clk_en` cleared on the same edge.
  - **FAIL**: `pll_core_rst`=1; `err`=1; `cfg_ready`=1; `clk_en`=0.
- Config accept (`cfg_valid && cfg_ready`, in RUN or FAIL):
  - `cfg_*` is latched into the shadow registers.
  - `err` and `retry_cnt` are cleared.
  - `locked` and `clk_en` are cleared.
  - The FSM goes to RST_HOLD.
- Any `cfg_*` field equal to 0 is substituted with 1 when latched.
- Simultaneous config accept and lock loss in RUN: the accept wins; the new config is applied.
- `dyn_*` only change while `pll_core_rst`=1.
- `cfg_valid` is ignored while `cfg_ready`=0. The requester must hold `cfg_valid` until the handshake completes.
- Async `pll_rst` mid-sequence: all outputs return to their reset values immediately, and `dyn_*` return to `DEF_*`. The previous shadow contents are discarded.

## Timing
- Accept at edge N:
  - Edge N: `pll_core_rst`=1, `cfg_ready`=0, `locked`=0, `clk_en`=0.
  - Edge N+1: `dyn_*` take the new values.
- `pll_core_rst` falls exactly `RST_HOLD_CYC` edges after entering RST_HOLD.
- `locked` rises `LOCK_STABLE_CYC` edges after `lock_s` first rises, where `lock_s` lags `pll_lock` by 2 cycles. `clk_en` rises on the same edge.
- Lock loss in RUN: `locked` falls 3 edges after `pll_lock` falls (2 synchroniser edges, then 1 registered edge). `pll_core_rst` rises on the same edge as `locked` falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `pll_cfg_pkg` holds:
  - the state enum;
  - `RATIO_W`;
  - the default ratio and duty constants (50 MHz in, VCO 625 MHz);
  - a function that clamps zero ratio fields to 1.
- Sub-module `pll_lock_sync`: a parametrised-depth synchroniser (depth 2) used for `pll_lock`.

## Test plan
- Power-up with `pll_lock` driven high 40 cycles after `pll_core_rst` falls:
  - `pll_core_rst` is high for 16 cycles;
  - `dyn_odiv` = {26,5,25};
  - `locked` and `clk_en`=3'b111 rise exactly 1024 cycles after `lock_s` rises.
- In RUN, apply a config of idiv 1, fdiv 30, odiv {10,2,10}:
  - `cfg_ready` drops on the accept edge;
  - `dyn_*` update 1 edge later while `pll_core_rst`=1;
  - the lock sequence completes.
- Hold `pll_lock` low with `LOCK_TIMEOUT_CYC`=256:
  - `retry_cnt` steps 1, 2, 3;
  - the FSM enters FAIL with `err`=1 and `pll_core_rst`=1;
  - a new config clears `err`.
- In RUN, drop `pll_lock` for 1 cycle:
  - `locked` falls 3 edges later;
  - a full RST_HOLD follows.
- Glitch `pll_lock` low at stable-count 500:
  - the FSM returns to WAIT_LOCK;
  - `locked` asserts only after a fresh run of 1024 consecutive high cycles.
- Assert `pll_rst` asynchronously during STABLE_CHK after a config with a zero field:
  - outputs reset immediately and `dyn_*` = `DEF_*`.
  - Separately, a config with a zero field yields 1 on the corresponding `dyn_*` field.
